bitrev_master: RTL and testbench
================================

# bitrev_master

SPI-style initiator that drives the bit-reversal peripheral's `sck`/`ss`/`mosi` pins and collects its `miso` reply. On each accepted request it sends one byte MSB-first, then clocks eight more bits to read the reversed byte back. It presents the result on a one-cycle response strobe. It sits between an on-chip requester (bus bridge or test driver) and the off-chip/peripheral SPI pins, and runs entirely on the system clock.

## Interface
- `DIV`, default 2: system-clock cycles per `sck` half-period; legal range 1..255.
- `clock` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present; `tx_data` valid.
- `req_ready` output 1: block idle, request accepted when both high at a clock edge.
- `tx_data` input 8: byte to send.
- `resp_valid` output 1: one-cycle pulse, `rx_data` is new.
- `rx_data` output 8: received byte; holds until the next response.
- `err` output 1: check mismatch flag (see Configuration).
- `sck` output 1: serial clock, idle low.
- `ss` output 1: select, active low, idle high.
- `mosi` output 1: serial data out, idle 0.
- `miso` input 1: serial data in.

## Operation
- States: IDLE, LOW, HIGH, END.
- IDLE: `req_ready`=1, `ss`=1, `sck`=0, `mosi`=0. On accept: latch `tx_data` into shift register, `ss`<=0, `mosi`<=tx[7], bit index<=0, phase counter<=0, go to LOW.
- LOW: count DIV cycles. On the last one, `sck`<=1; if bit index ≥8, shift `miso` into the rx register (`rx`<={rx[6:0],miso}) on that same edge, using the value before `sck` rises. Go to HIGH.
- HIGH: count DIV cycles. On the last one, `sck`<=0.
  - If bit index=15, go to END.
  - Otherwise increment the bit index and drive `mosi`<=tx[6-k] for the next bit k+1≤7, or 0 for bits 8..15. Go to LOW.
- END: hold `ss`=0 for DIV cycles, then `ss`<=1, `rx_data`<=rx, `resp_valid`<=1 for one cycle, go to IDLE.
- Bit counter is 4 bits and the phase counter is 8 bits; neither wraps within a frame.
- `req_ready` is combinational: it is 1 exactly when the state is IDLE. Requests outside IDLE are ignored and not queued.
- No response backpressure: `resp_valid` fires regardless of downstream.
- For a conforming peripheral, `rx_data` equals `tx_data` bit-reversed.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE.
  - `ss`=1, `sck`=0, `mosi`=0.
  - `resp_valid`=0, `rx_data`=0x00, `err`=0, counters 0.
  - No response is produced for the aborted frame.

## Timing
- Accept at edge T0. `ss` falls and the first `mosi` bit is valid after T0.
- Bit k (0..15): `sck` rises at T0+(2k+1)·DIV and falls at T0+(2k+2)·DIV.
- `mosi` changes only on `sck` falling edges and is stable for the whole high phase.
- `miso` samples are taken at the rising edges of bits 8..15.
- `ss` rises and `resp_valid` pulses at T0+33·DIV. Frame latency is 33·DIV cycles.
- `req_ready` is 1 after T0+33·DIV. The earliest next accept is T0+33·DIV+1, giving a minimum `ss` high time of 1 cycle between frames.
- If a request is held through `resp_valid`, the next accept comes one cycle after the pulse.

## Configuration
- `BITREV_MASTER_CHECK_EN` defined:
  - At the END→IDLE edge, compare the received byte with bit-reversed `tx`.
  - Drive `err`=1 together with `resp_valid` on a mismatch.
  - `err` stays 1 until the next accept or reset.
- Not defined: `err` is tied to 0 and no compare logic exists.
- Serial pin timing is identical with or without the macro.

## Test plan
- DIV=2, `tx_data`=0x01, bitrev peripheral attached -> `resp_valid` at T0+66, `rx_data`=0x80, `err`=0.
- DIV=1, `tx_data`=0xA5 -> `mosi` sequence 1,0,1,0,0,1,0,1 then zeros, 16 `sck` pulses of width 1, `rx_data`=0xA5.
- Back-to-back: 0x0F then 0x3C with `req_valid` held -> `ss` high exactly 1 cycle between frames; responses 0xF0 then 0x3C; `req_ready`=0 throughout each frame.
- Reset asserted at bit 5 of frame 0x55 -> `ss`=1, `sck`=0 immediately, no `resp_valid`. Next request 0x80 returns 0x01.
- `miso` forced 1, `tx_data`=0x12 -> `rx_data`=0xFF. With `BITREV_MASTER_CHECK_EN`, `err`=1 at the pulse and clears at the next accept. Without it, `err`=0.
- `req_valid` pulsed while busy -> ignored, exactly one response per accepted request.

Source files
------------

// File: rtl/bitrev_master.sv
// bitrev_master: SPI-style initiator for the bit-reversal peripheral.
// Each accepted request sends one byte MSB-first on mosi, then clocks eight
// more sck periods to read the reversed byte back on miso. The result is
// presented on a one-cycle resp_valid strobe. Frame latency is 33*DIV cycles.
//
// Parameters:
//   DIV        system-clock cycles per sck half-period (1..255)
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  request present, tx_data valid
//   req_ready  high exactly while idle; accept = req_valid & req_ready
//   tx_data    byte to send
//   resp_valid one-cycle pulse, rx_data is new
//   rx_data    received byte, held until the next response
//   err        received byte differs from bit-reversed tx (check build only)
//   sck        serial clock, idle low
//   ss         select, active low, idle high
//   mosi       serial data out, idle 0
//   miso       serial data in
//
// Optional feature: define BITREV_MASTER_CHECK_EN to compare the received
// byte against the bit-reversed transmit byte and raise err on mismatch.
// Without it err is tied low.
module bitrev_master #(
  parameter int unsigned DIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] tx_data,
  output logic       resp_valid,
  output logic [7:0] rx_data,
  output logic       err,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_END
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_phase;
  logic [3:0] r_bit;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic       w_accept;
  logic       w_phase_last;

  assign req_ready    = (r_state == ST_IDLE);
  assign w_accept     = req_valid && req_ready;
  assign w_phase_last = (r_phase == 8'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)     w_state_nxt = ST_LOW;
      ST_LOW:  if (w_phase_last) w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_phase_last) w_state_nxt = (r_bit == 4'd15) ? ST_END : ST_LOW;
      ST_END:  if (w_phase_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin, counter and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase    <= 8'd0;
      r_bit      <= 4'd0;
      sck        <= 1'b0;
      ss         <= 1'b1;
      mosi       <= 1'b0;
      resp_valid <= 1'b0;
      rx_data    <= 8'h00;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            ss      <= 1'b0;
            mosi    <= tx_data[7];
            r_bit   <= 4'd0;
            r_phase <= 8'd0;
          end
        end
        ST_LOW: begin
          if (w_phase_last) begin
            sck     <= 1'b1;
            r_phase <= 8'd0;
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        ST_HIGH: begin
          if (w_phase_last) begin
            sck     <= 1'b0;
            r_phase <= 8'd0;
            if (r_bit != 4'd15) begin
              r_bit <= r_bit + 4'd1;
              // bits 1..7 come from the latched byte, read-back bits send 0
              mosi  <= (r_bit < 4'd7) ? r_tx[3'd6 - r_bit[2:0]] : 1'b0;
            end
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        ST_END: begin
          if (w_phase_last) begin
            ss         <= 1'b1;
            rx_data    <= r_rx;
            resp_valid <= 1'b1;
            r_phase    <= 8'd0;
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shift data: no reset needed, every frame fully overwrites both
  always_ff @(posedge clock) begin
    if (w_accept) r_tx <= tx_data;
    // miso is sampled on the edge that raises sck, i.e. before the rise
    if (r_state == ST_LOW && w_phase_last && r_bit[3]) r_rx <= {r_rx[6:0], miso};
  end

`ifdef BITREV_MASTER_CHECK_EN
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                err <= 1'b0;
    else if (w_accept)                        err <= 1'b0;
    else if (r_state == ST_END && w_phase_last) err <= (r_rx != bitrev8(r_tx));
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitrev_master.sv
module tb_bitrev_master;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic       clock;
  logic       reset;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic [7:0] tx_data    [2];
  logic       resp_valid [2];
  logic [7:0] rx_data    [2];
  logic       err        [2];
  logic       sck        [2];
  logic       ss         [2];
  logic       mosi       [2];
  logic       miso       [2];
  bit         force_miso [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bitrev_master #(.DIV(DIV0)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .tx_data(tx_data[0]), .resp_valid(resp_valid[0]), .rx_data(rx_data[0]), .err(err[0]),
    .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]), .miso(miso[0]));

  bitrev_master #(.DIV(DIV1)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .tx_data(tx_data[1]), .resp_valid(resp_valid[1]), .rx_data(rx_data[1]), .err(err[1]),
    .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]), .miso(miso[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural bit-reversal peripheral: captures 8 bits on sck rising,
  // then returns them last-received-first so the master sees the reverse.
  for (genvar g = 0; g < 2; g++) begin : g_per
    int         cnt;
    logic [7:0] rxb;
    always @(posedge sck[g] or posedge ss[g]) begin
      if (ss[g]) cnt <= 0;
      else begin
        if (cnt < 8) rxb <= {rxb[6:0], mosi[g]};
        cnt <= cnt + 1;
      end
    end
    assign miso[g] = force_miso[g] ? 1'b1 :
                     (cnt >= 8 && cnt < 16) ? rxb[3'(cnt - 8)] : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full frame on instance i with timing, pin and result checks.
  task automatic run_frame(input int i, input logic [7:0] tx, input bit forced,
                           input logic [7:0] exp_rx, input logic exp_err);
    int          div;
    int          guard, t0, tr, hi, nrise, wbad, rbad;
    logic        prev, held;
    logic [15:0] bits;
    bit          rv;
    div = (i == 0) ? DIV0 : DIV1;
    force_miso[i] = forced;
    @(negedge clock);
    tx_data[i]   = tx;
    req_valid[i] = 1'b1;
    guard = 0;
    while (req_ready[i] !== 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    t0 = cyc + 1;
    @(negedge clock);
    req_valid[i] = 1'b0;
    chk("ss_low_after_accept", ss[i], 1'b0);
    chk("mosi_first_bit", mosi[i], tx[7]);
    chk("err_clear_at_accept", err[i], 1'b0);
    prev = 1'b0; held = 1'b0; hi = 0; nrise = 0; wbad = 0; rbad = 0;
    bits = 16'h0; rv = 0; guard = 0; tr = 0;
    while (!rv && guard < 40 * div + 20) begin
      if (sck[i] && !prev) begin
        bits  = {bits[14:0], mosi[i]};
        nrise++;
        held  = mosi[i];
      end
      if (sck[i]) begin
        hi++;
        if (mosi[i] !== held) wbad++;
      end
      if (!sck[i] && prev) begin
        if (hi != div) wbad++;
        hi = 0;
      end
      if (req_ready[i] !== 1'b0 || ss[i] !== 1'b0) rbad++;
      prev = sck[i];
      @(negedge clock);
      guard++;
      if (resp_valid[i] === 1'b1) begin
        rv = 1;
        tr = cyc;
      end
    end
    chk("resp_seen", rv, 1'b1);
    if (rv) begin
      chk("latency", tr - t0, 33 * div);
      chk("rx_data", rx_data[i], exp_rx);
      chk("err_at_pulse", err[i], exp_err);
      chk("sck_pulses", nrise, 16);
      chk("mosi_seq", bits, {tx, 8'h00});
      chk("sck_width_mosi_stable", wbad, 0);
      chk("busy_ready_ss", rbad, 0);
      chk("ss_high_at_pulse", ss[i], 1'b1);
      @(negedge clock);
      chk("resp_one_cycle", resp_valid[i], 1'b0);
      chk("rx_data_hold", rx_data[i], exp_rx);
    end
    force_miso[i] = 0;
  endtask

  typedef struct {
    int         inst;
    logic [7:0] tx;
    bit         forced;
    logic [7:0] rx;
  } vec_t;

  initial begin
    vec_t        tbl [8];
    logic [7:0]  q [$];
    logic        e;
    int          guard, run, gap, rbad, nresp, rises;
    logic        prev;
    logic [7:0]  rtx, last_rx;
    bit          rf;

    tbl[0] = '{0, 8'h01, 1'b0, 8'h80};
    tbl[1] = '{1, 8'hA5, 1'b0, 8'hA5};
    tbl[2] = '{0, 8'h0F, 1'b0, 8'hF0};
    tbl[3] = '{1, 8'h3C, 1'b0, 8'h3C};
    tbl[4] = '{0, 8'h12, 1'b1, 8'hFF};
    tbl[5] = '{0, 8'h80, 1'b0, 8'h01};
    tbl[6] = '{1, 8'h00, 1'b0, 8'h00};
    tbl[7] = '{1, 8'hFF, 1'b0, 8'hFF};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; tx_data[i] = 8'h00; force_miso[i] = 0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ss", ss[i], 1'b1);
      chk("rst_sck", sck[i], 1'b0);
      chk("rst_mosi", mosi[i], 1'b0);
      chk("rst_resp", resp_valid[i], 1'b0);
      chk("rst_rx", rx_data[i], 8'h00);
      chk("rst_err", err[i], 1'b0);
      chk("rst_ready", req_ready[i], 1'b1);
    end
    reset = 1'b0;

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
`ifdef BITREV_MASTER_CHECK_EN
      e = tbl[k].forced && (tbl[k].rx != rev8(tbl[k].tx));
`else
      e = 1'b0;
`endif
      run_frame(tbl[k].inst, tbl[k].tx, tbl[k].forced, tbl[k].rx, e);
    end

    // Randomized frames against the reversal model
    for (int k = 0; k < 12; k++) begin
      rtx = 8'($urandom);
      rf  = ($urandom_range(0, 3) == 0);
`ifdef BITREV_MASTER_CHECK_EN
      e = rf && (rev8(rtx) != 8'hFF);
`else
      e = 1'b0;
`endif
      run_frame(k % 2, rtx, rf, rf ? 8'hFF : rev8(rtx), e);
    end

    // Back-to-back with req_valid held
    @(negedge clock);
    tx_data[0] = 8'h0F; req_valid[0] = 1'b1;
    @(negedge clock);
    tx_data[0] = 8'h3C;
    q.delete(); run = 0; gap = -1; rbad = 0; guard = 0;
    while (q.size() < 2 && guard < 200) begin
      @(negedge clock);
      guard++;
      if (resp_valid[0]) q.push_back(rx_data[0]);
      if (ss[0]) run++;
      else begin
        if (run > 0 && gap < 0) gap = run;
        run = 0;
        if (req_ready[0] !== 1'b0) rbad++;
        if (q.size() == 1) req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    chk("b2b_resp_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("b2b_rx0", q[0], 8'hF0);
      chk("b2b_rx1", q[1], 8'h3C);
    end
    chk("b2b_ss_gap", gap, 1);
    chk("b2b_ready_busy", rbad, 0);
    repeat (3) @(negedge clock);

    // Reset in the middle of bit 5 of frame 0x55
    tx_data[0] = 8'h55; req_valid[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    rises = 0; prev = 1'b0; guard = 0;
    while (rises < 6 && guard < 100) begin
      @(negedge clock);
      guard++;
      if (sck[0] && !prev) rises++;
      prev = sck[0];
    end
    chk("rst_mid_reached_bit5", rises, 6);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ss", ss[0], 1'b1);
    chk("rst_mid_sck", sck[0], 1'b0);
    chk("rst_mid_mosi", mosi[0], 1'b0);
    chk("rst_mid_resp", resp_valid[0], 1'b0);
    chk("rst_mid_ready", req_ready[0], 1'b1);
    @(negedge clock);
    reset = 1'b0;
    nresp = 0;
    repeat (80) begin
      @(negedge clock);
      if (resp_valid[0]) nresp++;
    end
    chk("rst_mid_no_resp", nresp, 0);
    run_frame(0, 8'h80, 0, 8'h01, 1'b0);

    // Request pulsed while busy is ignored
    @(negedge clock);
    tx_data[0] = 8'h33; req_valid[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    repeat (10) @(negedge clock);
    tx_data[0] = 8'h77; req_valid[0] = 1'b1;
    chk("busy_ready_low", req_ready[0], 1'b0);
    @(negedge clock);
    req_valid[0] = 1'b0;
    nresp = 0; last_rx = 8'h00;
    repeat (150) begin
      @(negedge clock);
      if (resp_valid[0]) begin
        nresp++;
        last_rx = rx_data[0];
      end
    end
    chk("busy_single_resp", nresp, 1);
    chk("busy_rx", last_rx, 8'hCC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
